// File: rtl/ahbl_sram_slave.sv
// ahbl_sram_slave
//   AHB-Lite SRAM slave with a programmable number of data-phase wait states.
//   The memory holds 2^(AW-2) 32-bit words. Byte and halfword writes update
//   only the addressed lanes. A read returns the whole word during the final
//   data-phase cycle and 0 in every other cycle. Memory contents are not reset.
//
// Parameters
//   AW           byte-address width (HADDR bits above AW-1 alias)
//   WAIT_STATES  data-phase cycles with HREADYOUT low, 0..7
//
// Ports
//   HCLK       in   clock, rising edge
//   HRESETn    in   asynchronous reset, active-high
//   HSEL       in   slave select
//   HADDR      in   [31:0] transfer address
//   HTRANS     in   [1:0] transfer type, bit 1 set for NONSEQ/SEQ
//   HSIZE      in   [2:0] transfer size
//   HWRITE     in   1 = write
//   HWDATA     in   [31:0] write data (data phase)
//   HREADY     in   bus ready, completes the address phase
//   HREADYOUT  out  slave ready
//   HRDATA     out  [31:0] read data
//   HRESP      out  response, always OKAY
module ahbl_sram_slave #(
    parameter int AW          = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP
);

    localparam int DEPTH = 1 << (AW - 2);

    if (WAIT_STATES < 0 || WAIT_STATES > 7) begin : g_bad_wait_states
        $fatal(1, "ahbl_sram_slave: WAIT_STATES must be within 0..7");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_LAST = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [2:0]      wcnt;
    logic [2:0]      wcnt_nxt;
    logic [AW-1:0]   addr_q;
    logic [2:0]      size_q;
    logic            write_q;
    logic            accept;
    logic            commit;
    logic [3:0]      lane_en;
    logic [AW-3:0]   word_idx;
    logic [31:0]     mem [0:DEPTH-1];
    logic            unused_bits;

    // HREADY is low while this slave stalls, so no new address phase can
    // complete during WAIT.
    assign accept   = HSEL & HTRANS[1] & HREADY & (state != ST_WAIT);
    assign commit   = (state == ST_LAST) & write_q;
    assign word_idx = addr_q[AW-1:2];

    assign unused_bits = ^{HADDR[31:AW], HTRANS[0]};

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            ST_IDLE, ST_LAST: begin
                if (accept) begin
                    wcnt_nxt  = 3'(WAIT_STATES);
                    state_nxt = (WAIT_STATES > 0) ? ST_WAIT : ST_LAST;
                end else if (state == ST_LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                wcnt_nxt = wcnt - 3'd1;
                if (wcnt == 3'd1) begin
                    state_nxt = ST_LAST;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                wcnt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESETn) begin
        if (HRESETn) begin
            state   <= ST_IDLE;
            wcnt    <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if (accept) begin
                addr_q  <= HADDR[AW-1:0];
                size_q  <= HSIZE;
                write_q <= HWRITE;
            end
        end
    end

    // Low address bits below the transfer size are ignored, which aligns
    // unaligned accesses.
    always_comb begin
        lane_en = '0;
        case (size_q)
            3'd0:    lane_en[addr_q[1:0]] = 1'b1;
            3'd1:    lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    end

    // The write lands at the edge ending LAST; a transfer accepted in the same
    // cycle therefore sees the updated word in its own data phase. Reset drops
    // state out of LAST immediately, so an aborted write never commits.
    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int unsigned n = 0; n < 4; n++) begin
                if (lane_en[n]) begin
                    mem[word_idx][8*n +: 8] <= HWDATA[8*n +: 8];
                end
            end
        end
    end

    always_comb begin
        HRDATA = '0;
        if (state == ST_LAST && !write_q) begin
            HRDATA = mem[word_idx];
        end
    end

    assign HREADYOUT = (state != ST_WAIT);
    assign HRESP     = 1'b0;

endmodule

// File: doc/ahbl_sram_slave.md
AHBL_SRAM_SLAVE -- requirements
Module: ahbl_sram_slave

Interface
REQ-001 The block SHALL have these parameters:
- AW, 10, byte-address width; the memory holds 2^(AW-2) 32-bit words.
- WAIT_STATES, 1, number of data-phase cycles with HREADYOUT low; legal range 0..7.

REQ-002 The block SHALL have these ports:
- HCLK  in  1  clock; all state changes on its rising edge.
- HRESETn  in  1  reset, asynchronous, active-high.
- HSEL  in  1  slave select from the address decoder.
- HADDR  in  32  transfer address.
- HTRANS  in  2  transfer type; HTRANS[1]=1 means NONSEQ/SEQ.
- HSIZE  in  3  transfer size: 0 byte, 1 halfword, 2 word.
- HWRITE  in  1  1 = write, 0 = read.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-level ready; marks the address phase as complete.
- HREADYOUT  out  1  this slave's ready.
- HRDATA  out  32  read data.
- HRESP  out  1  response; always 0 (OKAY).

Function
REQ-003 The block SHALL accept a transfer at a rising edge where HSEL=1, HTRANS[1]=1 and HREADY=1; it SHALL register HADDR[AW-1:0], HSIZE and HWRITE at that edge.
REQ-004 The block SHALL ignore HADDR bits above AW-1, so addresses alias modulo 2^AW; the word index SHALL be HADDR[AW-1:2].
REQ-005 The FSM SHALL have three states:
- IDLE: HREADYOUT=1.
- WAIT: HREADYOUT=0.
- LAST: HREADYOUT=1; the final data-phase cycle.
REQ-006 On an accepted transfer from IDLE or LAST, the FSM SHALL go to WAIT with wcnt=WAIT_STATES when WAIT_STATES>0, otherwise to LAST.
REQ-007 In WAIT the block SHALL decrement the 3-bit wcnt; when wcnt=1 the next state SHALL be LAST.
REQ-008 From LAST, with no accepted transfer, the FSM SHALL go to IDLE.
REQ-009 HREADYOUT SHALL be low for exactly WAIT_STATES cycles per data phase.
REQ-010 Transfers with HTRANS[1]=0 (IDLE/BUSY), or with HSEL=0, SHALL cause no state change and SHALL get a zero-wait OKAY (HREADYOUT=1).
REQ-011 The block SHALL derive byte lanes from the registered size and address:
- Size 0: lane addr[1:0].
- Size 1: lanes {addr[1],0} and {addr[1],1}.
- Size 2, and sizes 3..7: all four lanes.
REQ-012 The block SHALL force unaligned addresses to alignment by ignoring the low bits below the size.
REQ-013 A write SHALL update only the enabled lanes from the same lanes of HWDATA (lane n = HWDATA[8n+7:8n]). The update SHALL happen at the rising edge that ends the LAST cycle. HWDATA SHALL be sampled only at that edge.
REQ-014 During LAST of a read, HRDATA SHALL be the full word mem[addr_q] (combinational from the array). The master masks sub-word data itself.
REQ-015 In all other cycles HRDATA SHALL be 32'h0.
REQ-016 Pipelined transfers SHALL be supported. A transfer accepted in LAST SHALL start its data phase at the edge where the previous write commits. A read of the same word SHALL therefore return the newly written bytes.
REQ-017 HRESP SHALL be tied to 0; there are no error responses.
REQ-018 WAIT_STATES outside 0..7 SHALL be a fatal elaboration error.

Reset
REQ-019 While HRESETn=1 the block SHALL hold state=IDLE, wcnt=0, HREADYOUT=1, HRDATA=0, HRESP=0, and clear the registered addr, size and write.
REQ-020 Reset asserted mid-transfer SHALL abort the transfer; a pending write SHALL NOT modify memory.
REQ-021 Memory contents SHALL NOT be reset; unwritten words are undefined.
REQ-022 After reset deasserts, the block SHALL accept a transfer at the first qualifying edge.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset: HRESETn=1 -> HREADYOUT=1, HRDATA=0, HRESP=0 immediately, without waiting for a clock edge.
- WAIT_STATES=1: word write 0x12345670 @0x0, then word read @0x0 -> each data phase has HREADYOUT low exactly 1 cycle; read returns HRDATA=0x12345670.
- Byte and halfword writes after word 0x12345670 @0x0:
  - byte write @0x3 with HWDATA=0xAB000000 -> read @0x0 returns 0xAB345670;
  - then halfword write @0x0 with HWDATA=0x0000BEEF -> read returns 0xAB34BEEF.
- Aliasing and select: word write 0xCAFEF00D @0x20000004 -> read @0x4 returns 0xCAFEF00D. A NONSEQ with HSEL=0 -> HREADYOUT stays 1 and memory is unchanged.
- WAIT_STATES=0, pipelined: write 0x11111111 @0x8 immediately followed by read @0x8 -> HREADYOUT never low; read data phase returns 0x11111111.
- Reset during the WAIT cycle of a write of 0xDEADBEEF @0xC, where the word held 0x0 -> after reset, read @0xC returns 0x0 and HREADYOUT=1.
